// File: rtl/led_seq_pkg.sv
// Shared mode encodings for the LED sequencer and its optional PWM stage.
package led_seq_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF    = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

endpackage

// File: rtl/led_sequencer_pwm.sv
// Free-running PWM counter plus duty compare; built only with LED_SEQ_PWM_EN.
module led_pwm #(
  parameter int PWM_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [PWM_W-1:0] brightness,
  output logic             pwm_on
);

  logic [PWM_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (enable) cnt_d = cnt_q + PWM_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Strict less-than: brightness=0 is fully dark, all-ones is one short of full duty.
  assign pwm_on = (cnt_q < brightness);

endmodule

// File: rtl/led_sequencer.sv
// LED pattern sequencer: prescaled stepping through OFF/BOUNCE/CHASE/BLINK patterns.
// Optional PWM dimming is compiled in when LED_SEQ_PWM_EN is defined.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int NUM_LEDS   = 6,
  parameter int PRESCALE_W = 26,
  parameter int PWM_W      = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enable,
  input  logic [MODE_W-1:0]     mode,
  input  logic [PRESCALE_W-1:0] step_period,
  input  logic [PWM_W-1:0]      brightness,
  output logic [NUM_LEDS-1:0]   led,
  output logic                  step_pulse
);

  localparam int POS_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0] POS_LAST   = POS_W'(NUM_LEDS - 1);
  localparam logic [POS_W-1:0] POS_PENULT = POS_W'((NUM_LEDS > 1) ? NUM_LEDS - 2 : 0);

  logic [PRESCALE_W-1:0] presc_q, presc_d;
  logic [POS_W-1:0]      pos_q, pos_d;
  logic                  dir_q, dir_d;
  logic                  phase_q, phase_d;
  mode_e                 mode_prev_q, mode_prev_d;
  logic [NUM_LEDS-1:0]   led_q, led_d;
  logic                  step_pulse_q, step_pulse_d;

  mode_e               mode_in;
  logic                mode_change;
  logic                step;
  logic                pwm_on;
  logic [NUM_LEDS-1:0] pattern;

  assign mode_in     = mode_e'(mode);
  assign mode_change = (mode_in != mode_prev_q);
  // A mode change suppresses any terminal count on the same edge.
  assign step        = enable && !mode_change && (presc_q >= step_period);

`ifdef LED_SEQ_PWM_EN
  led_pwm #(.PWM_W(PWM_W)) u_pwm (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .brightness (brightness),
    .pwm_on     (pwm_on)
  );
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pwm_on = 1'b1;
`endif

  // Pattern comes from registered state, so led trails pos/phase by one clock.
  always_comb begin
    pattern = '0;
    case (mode_prev_q)
      MODE_BOUNCE, MODE_CHASE: pattern = NUM_LEDS'(1) << pos_q;
      MODE_BLINK:              pattern = {NUM_LEDS{phase_q}};
      default:                 pattern = '0;
    endcase
  end

  always_comb begin
    presc_d      = presc_q;
    pos_d        = pos_q;
    dir_d        = dir_q;
    phase_d      = phase_q;
    mode_prev_d  = mode_in;
    step_pulse_d = step;
    led_d        = enable ? (pattern & {NUM_LEDS{pwm_on}}) : '0;

    if (mode_change) begin
      presc_d = '0;
      pos_d   = '0;
      dir_d   = 1'b0;
      phase_d = 1'b0;
    end else if (enable) begin
      if (step) begin
        presc_d = '0;
        case (mode_in)
          MODE_CHASE: begin
            pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
          end
          MODE_BOUNCE: begin
            if (NUM_LEDS == 1) begin
              pos_d = '0;
            end else if (!dir_q) begin
              if (pos_q == POS_LAST) begin
                dir_d = 1'b1;
                pos_d = POS_PENULT;
              end else begin
                pos_d = pos_q + POS_W'(1);
              end
            end else begin
              if (pos_q == '0) begin
                dir_d = 1'b0;
                pos_d = POS_W'(1);
              end else begin
                pos_d = pos_q - POS_W'(1);
              end
            end
          end
          MODE_BLINK: phase_d = ~phase_q;
          default: ;
        endcase
      end else begin
        presc_d = presc_q + PRESCALE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      presc_q      <= '0;
      pos_q        <= '0;
      dir_q        <= 1'b0;
      phase_q      <= 1'b0;
      mode_prev_q  <= MODE_OFF;
      led_q        <= '0;
      step_pulse_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      pos_q        <= pos_d;
      dir_q        <= dir_d;
      phase_q      <= phase_d;
      mode_prev_q  <= mode_prev_d;
      led_q        <= led_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  assign led        = led_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Directed bench for led_sequencer with NUM_LEDS=6; PWM checks run when LED_SEQ_PWM_EN is defined.
module tb_led_sequencer;

  localparam int N  = 6;
  localparam int PW = 26;
  localparam int BW = 8;

  localparam logic [1:0] M_OFF    = 2'd0;
  localparam logic [1:0] M_BOUNCE = 2'd1;
  localparam logic [1:0] M_CHASE  = 2'd2;
  localparam logic [1:0] M_BLINK  = 2'd3;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b1;
  logic [1:0]    mode = M_OFF;
  logic [PW-1:0] step_period = '0;
  logic [BW-1:0] brightness = 8'd255;
  logic [N-1:0]  led;
  logic          step_pulse;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  led_sequencer #(.NUM_LEDS(N), .PRESCALE_W(PW), .PWM_W(BW)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .enable      (enable),
    .mode        (mode),
    .step_period (step_period),
    .brightness  (brightness),
    .led         (led),
    .step_pulse  (step_pulse)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Clocks until step_pulse is seen; max+1 when the budget runs out.
  task automatic wait_step(input int max, output int n);
    n = 0;
    while (n < max) begin
      tick();
      n++;
      if (step_pulse) return;
    end
    n = max + 1;
  endtask

  // Reset, then release with the given mode; returns just after the first live edge.
  task automatic do_reset(input logic [1:0] m, input logic [PW-1:0] per);
    rstn        = 1'b0;
    enable      = 1'b1;
    mode        = m;
    step_period = per;
    tick();
    tick();
    check("rst_led", 32'(led), 32'h0);
    check("rst_pulse", 32'(step_pulse), 32'h0);
    rstn = 1'b1;
    tick();
    check("first_edge_no_pulse", 32'(step_pulse), 32'h0);
  endtask

  initial begin
    int n;
    int bounce_exp[12];
    bounce_exp = '{1, 2, 4, 8, 16, 32, 16, 8, 4, 2, 1, 2};

    // CHASE, period 3: one step every 4 clocks, led wraps after LED5
    do_reset(M_CHASE, 26'd3);
    tick();
    check("chase_led0", 32'(led), 32'h01);
    wait_step(8, n);
    check("chase_first_step", 32'(n), 32'd3);
    for (int k = 0; k < 7; k++) begin
      tick();
      check("chase_led", 32'(led), 32'(1 << ((k + 1) % 6)));
      check("chase_pulse_low", 32'(step_pulse), 32'h0);
      wait_step(8, n);
      check("chase_interval", 32'(n + 1), 32'd4);
    end

    // BOUNCE, period 0: step every clock, no repeated endpoint
    do_reset(M_BOUNCE, 26'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("bounce_led", 32'(led), 32'(bounce_exp[k]));
      check("bounce_pulse", 32'(step_pulse), 32'h1);
    end

    // CHASE at pos 3, switch to BLINK on the terminal-count edge
    do_reset(M_CHASE, 26'd3);
    for (int k = 0; k < 3; k++) begin
      wait_step(8, n);
      check("pre_blink_step", 32'(n), 32'd4);
    end
    tick();
    tick();
    tick();
    mode = M_BLINK;
    tick();
    check("blink_switch_no_pulse", 32'(step_pulse), 32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("blink_dark", 32'(led), 32'h0);
      check("blink_no_pulse", 32'(step_pulse), 32'h0);
    end
    tick();
    check("blink_first_step", 32'(step_pulse), 32'h1);
    check("blink_still_dark", 32'(led), 32'h0);
    tick();
    check("blink_on", 32'(led), 32'h3f);
    tick();
    tick();
    tick();
    check("blink_second_step", 32'(step_pulse), 32'h1);
    tick();
    check("blink_off", 32'(led), 32'h0);

    // enable dropped for 10 clocks mid-count
    do_reset(M_CHASE, 26'd3);
    wait_step(8, n);
    check("en_first_step", 32'(n), 32'd4);
    tick();
    check("en_led_pos1", 32'(led), 32'h02);
    tick();
    enable = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("frozen_led", 32'(led), 32'h0);
      check("frozen_pulse", 32'(step_pulse), 32'h0);
    end
    enable = 1'b1;
    tick();
    check("resume_led", 32'(led), 32'h02);
    check("resume_no_pulse", 32'(step_pulse), 32'h0);
    tick();
    check("resume_step", 32'(step_pulse), 32'h1);
    tick();
    check("resume_led_pos2", 32'(led), 32'h04);

    // Lowering step_period below the running count steps on the next edge
    do_reset(M_CHASE, 26'd7);
    wait_step(12, n);
    check("p7_first_step", 32'(n), 32'd8);
    for (int k = 0; k < 5; k++) tick();
    check("p7_no_pulse", 32'(step_pulse), 32'h0);
    step_period = 26'd2;
    tick();
    check("lowered_period_step", 32'(step_pulse), 32'h1);

    // OFF: dark, but the prescaler still produces steps
    do_reset(M_OFF, 26'd1);
    tick();
    check("off_pulse", 32'(step_pulse), 32'h1);
    check("off_led", 32'(led), 32'h0);
    tick();
    check("off_led2", 32'(led), 32'h0);

    // Reset mid-BOUNCE while moving down
    do_reset(M_BOUNCE, 26'd0);
    for (int k = 0; k < 7; k++) tick();
    check("bounce_down_led", 32'(led), 32'h10);
    rstn = 1'b0;
    tick();
    check("midrst_led", 32'(led), 32'h0);
    check("midrst_pulse", 32'(step_pulse), 32'h0);
    rstn = 1'b1;
    tick();
    check("midrst_restart_led", 32'(led), 32'h0);
    tick();
    check("restart_led0", 32'(led), 32'h01);
    tick();
    check("restart_led1", 32'(led), 32'h02);
    tick();
    check("restart_led2", 32'(led), 32'h04);

`ifdef LED_SEQ_PWM_EN
    begin
      int on_cnt;
      do_reset(M_CHASE, 26'd1000);
      brightness = 8'd64;
      tick();
      on_cnt = 0;
      for (int k = 0; k < 256; k++) begin
        tick();
        if (led != '0) on_cnt++;
      end
      check("pwm_duty_64", 32'(on_cnt), 32'd64);
      brightness = 8'd0;
      tick();
      on_cnt = 0;
      for (int k = 0; k < 256; k++) begin
        tick();
        if (led != '0) on_cnt++;
      end
      check("pwm_duty_0", 32'(on_cnt), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
